// File: rtl/t_sram_responder_pkg.sv
// Shared constants, state encoding and group packing helper for the T-column SRAM responder.
package t_sram_responder_pkg;

    localparam int unsigned T_PER_WORD    = 4;
    localparam int unsigned V_E_F_BIT     = 8;
    localparam int unsigned BIT_P_GROUP   = 2 + 2 * (V_E_F_BIT - 1);
    localparam int unsigned HEADER_BIT    = 4;
    localparam int unsigned DATA_W        = BIT_P_GROUP * T_PER_WORD;
    localparam int unsigned SRAM_WORD     = HEADER_BIT + DATA_W;
    localparam int unsigned MAX_T_LOG     = 10;
    localparam int unsigned DEPTH         = (2 ** MAX_T_LOG) / T_PER_WORD;
    localparam int unsigned ADDR_W        = $clog2(DEPTH);
    localparam int unsigned CNT_W         = HEADER_BIT - 1;
    localparam int unsigned SLOT_W        = $clog2(T_PER_WORD);
    localparam int unsigned OCC_W         = MAX_T_LOG + 1;
    localparam int unsigned STALL_W       = 16;

    // Header field offsets inside a response word.
    localparam int unsigned HDR_VALID_BIT = SRAM_WORD - 1;
    localparam int unsigned HDR_CNT_LSB   = DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Insert symbol t as group {t, V=0, F=0} into the given slot; slot 0 is most significant.
    function automatic logic [DATA_W-1:0] place_group(input logic [DATA_W-1:0] word,
                                                      input logic [SLOT_W-1:0] slot,
                                                      input logic [1:0]        t);
        logic [DATA_W-1:0] w;
        w = word;
        for (int unsigned s = 0; s < T_PER_WORD; s++) begin
            if (slot == SLOT_W'(s)) begin
                w[DATA_W - 1 - s * BIT_P_GROUP -: 2] = t;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/t_word_ram.sv
// Word storage: DEPTH x WIDTH register file, one write port, one registered read port.
module t_word_ram
    import t_sram_responder_pkg::*;
#(
    parameter int unsigned DEPTH_P = DEPTH,
    parameter int unsigned WIDTH_P = DATA_W,
    parameter int unsigned ADDR_P  = ADDR_W
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [ADDR_P-1:0]  waddr_i,
    input  logic [WIDTH_P-1:0] wdata_i,
    input  logic               re_i,
    input  logic [ADDR_P-1:0]  raddr_i,
    output logic [WIDTH_P-1:0] rdata_o
);

    logic [WIDTH_P-1:0] mem_q [DEPTH_P];
    logic [WIDTH_P-1:0] rdata_q;

    // Write commits at the edge; a read in the same cycle sees the old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/t_sram_responder.sv
// T-column SRAM responder: loads packed T groups, serves one word per DP request and
// accepts DP write-backs through a circular word FIFO that wraps at words-per-pass.
// Optional build macro: TSR_STALL_CNT_EN adds a saturating 16-bit o_stall_cnt output.
module t_sram_responder
    import t_sram_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MAX_T_LOG-1:0] i_T_size,
    input  logic                 i_load_valid,
    input  logic [1:0]           i_load_t,
    input  logic                 i_load_last,
    input  logic                 i_sram_request,
    output logic [SRAM_WORD-1:0] o_request_data,
    input  logic                 i_sram_send,
    input  logic [SRAM_WORD-1:0] i_send_data,
    input  logic                 i_sram_init,
    output logic                 o_load_ready,
`ifdef TSR_STALL_CNT_EN
    output logic                 o_error,
    output logic [STALL_W-1:0]   o_stall_cnt
`else
    output logic                 o_error
`endif
);

    state_e                state_q;
    logic [ADDR_W-1:0]     rd_q;
    logic [ADDR_W-1:0]     wr_q;
    logic [OCC_W-1:0]      occ_q;
    logic                  pending_q;
    logic [SLOT_W-1:0]     slot_q;
    logic [DATA_W-1:0]     pack_q;
    logic                  resp_valid_q;
    logic [CNT_W-1:0]      resp_cnt_q;
    logic                  load_ready_q;
    logic                  error_q;

    logic [MAX_T_LOG-1:0]  wpp;
    logic [MAX_T_LOG-1:0]  wpp_m1;
    logic [CNT_W-1:0]      last_cnt;
    logic                  rd_at_end;
    logic                  wr_at_end;
    logic [ADDR_W-1:0]     rd_d;
    logic [ADDR_W-1:0]     wr_d;
    logic                  occ_empty;
    logic                  occ_full;
    logic                  run;
    logic                  req_eff;
    logic                  rd_fire;
    logic                  send_ok;
    logic                  send_err;
    logic                  load_fire;
    logic                  load_word;
    logic [DATA_W-1:0]     pack_d;
    logic                  ram_we;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;
    logic                  unused_send_hdr;

    // Header bits of write-back words carry no information for storage.
    assign unused_send_hdr = ^i_send_data[SRAM_WORD-1:DATA_W];

    // Per-pass geometry, pointer wrap and request/send qualification.
    always_comb begin
        wpp       = (i_T_size >> SLOT_W) + MAX_T_LOG'(|i_T_size[SLOT_W-1:0]);
        wpp_m1    = wpp - MAX_T_LOG'(1);
        last_cnt  = CNT_W'(i_T_size[SLOT_W-1:0]);
        rd_at_end = (MAX_T_LOG'(rd_q) == wpp_m1);
        wr_at_end = (MAX_T_LOG'(wr_q) == wpp_m1);
        rd_d      = rd_at_end ? '0 : rd_q + ADDR_W'(1);
        wr_d      = wr_at_end ? '0 : wr_q + ADDR_W'(1);
        occ_empty = (occ_q == '0);
        occ_full  = (occ_q == OCC_W'(wpp));
        run       = (state_q == ST_RUN);
        // The DP re-asserts its request one cycle late, so the cycle after a response is ignored.
        req_eff   = pending_q | (i_sram_request & ~resp_valid_q);
        rd_fire   = run & ~i_sram_init & req_eff & ~occ_empty;
        send_ok   = run & ~i_sram_init & i_sram_send & ~occ_full;
        send_err  = i_sram_send & ~i_sram_init & (~run | occ_full);
        load_fire = (state_q == ST_IDLE || state_q == ST_LOAD) & ~i_sram_init & i_load_valid;
        load_word = load_fire & ((slot_q == SLOT_W'(T_PER_WORD - 1)) | i_load_last);
        pack_d    = place_group(pack_q, slot_q, i_load_t);
        ram_we    = load_word | send_ok;
        ram_wdata = load_word ? pack_d : i_send_data[DATA_W-1:0];
    end

    // FSM, pointers, occupancy, request latch and response header registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rd_q         <= '0;
            wr_q         <= '0;
            occ_q        <= '0;
            pending_q    <= 1'b0;
            slot_q       <= '0;
            pack_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_cnt_q   <= '0;
            load_ready_q <= 1'b1;
            error_q      <= 1'b0;
        end else begin
            resp_valid_q <= rd_fire;
            resp_cnt_q   <= rd_at_end ? last_cnt : '0;
            error_q      <= error_q | send_err;
            if (i_sram_init) begin
                state_q      <= ST_IDLE;
                rd_q         <= '0;
                wr_q         <= '0;
                occ_q        <= '0;
                pending_q    <= 1'b0;
                slot_q       <= '0;
                pack_q       <= '0;
                load_ready_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE, ST_LOAD: begin
                        if (load_fire) begin
                            if (load_word) begin
                                pack_q <= '0;
                                slot_q <= '0;
                                wr_q   <= wr_d;
                            end else begin
                                pack_q <= pack_d;
                                slot_q <= slot_q + SLOT_W'(1);
                            end
                            if (i_load_last) begin
                                state_q      <= ST_RUN;
                                load_ready_q <= 1'b0;
                                occ_q        <= OCC_W'(wpp);
                                rd_q         <= '0;
                                wr_q         <= '0;
                            end else begin
                                state_q <= ST_LOAD;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (rd_fire) begin
                            rd_q      <= rd_d;
                            pending_q <= 1'b0;
                        end else if (req_eff) begin
                            pending_q <= 1'b1;
                        end
                        if (send_ok) begin
                            wr_q <= wr_d;
                        end
                        if (rd_fire && !send_ok) begin
                            occ_q <= occ_q - OCC_W'(1);
                        end else if (send_ok && !rd_fire) begin
                            occ_q <= occ_q + OCC_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef TSR_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;

    // Saturating count of RUN cycles spent waiting on an empty FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (i_sram_init) begin
            stall_q <= '0;
        end else if (run && pending_q && occ_empty && (stall_q != '1)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign o_stall_cnt = stall_q;
`endif

    t_word_ram #(
        .DEPTH_P (DEPTH),
        .WIDTH_P (DATA_W),
        .ADDR_P  (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_q),
        .wdata_i (ram_wdata),
        .re_i    (rd_fire),
        .raddr_i (rd_q),
        .rdata_o (ram_rdata)
    );

    assign o_request_data = resp_valid_q ? {1'b1, resp_cnt_q, ram_rdata} : '0;
    assign o_load_ready   = load_ready_q;
    assign o_error        = error_q;

endmodule

// File: tb/tb_t_sram_responder.sv
// Scoreboard bench for t_sram_responder: a queue-based reference model predicts every
// response word and its cycle; a separate monitor compares what the DUT presents.
module tb_t_sram_responder;
    import t_sram_responder_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [MAX_T_LOG-1:0] t_size;
    logic                 load_valid;
    logic [1:0]           load_t;
    logic                 load_last;
    logic                 req;
    logic                 send;
    logic [SRAM_WORD-1:0] send_data;
    logic                 init;
    logic [SRAM_WORD-1:0] req_data;
    logic                 load_ready;
    logic                 err;
`ifdef TSR_STALL_CNT_EN
    logic [STALL_W-1:0]   stall_cnt;
`endif

    always #5 clk = ~clk;

    t_sram_responder dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_T_size       (t_size),
        .i_load_valid   (load_valid),
        .i_load_t       (load_t),
        .i_load_last    (load_last),
        .i_sram_request (req),
        .o_request_data (req_data),
        .i_sram_send    (send),
        .i_send_data    (send_data),
        .i_sram_init    (init),
        .o_load_ready   (load_ready),
`ifdef TSR_STALL_CNT_EN
        .o_error        (err),
        .o_stall_cnt    (stall_cnt)
`else
        .o_error        (err)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [SRAM_WORD-1:0] word;
        int                   at;
    } exp_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                pos;
    } ent_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: FIFO as a queue of (data, ring position) entries.
    ent_t       m_q[$];
    logic [1:0] m_buf[$];
    int         m_state;   // 0 idle, 1 load, 2 run
    int         m_wpos;
    int         m_wpp;
    bit         m_pending;
    bit         m_resp_now;
    bit         m_err;
    bit         exp_err   = 1'b0;
    bit         exp_ready = 1'b1;

    task automatic chk(input string name, input logic [SRAM_WORD-1:0] act, input logic [SRAM_WORD-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] build_word();
        logic [DATA_W-1:0] w;
        w = '0;
        foreach (m_buf[i]) w[DATA_W - 1 - i * BIT_P_GROUP -: 2] = m_buf[i];
        return w;
    endfunction

    function automatic logic [CNT_W-1:0] hdr_cnt(input int pos);
        if (pos == m_wpp - 1) return CNT_W'(int'(t_size) % T_PER_WORD);
        return '0;
    endfunction

    function automatic void model(input bit rs, input bit r, input bit s, input logic [DATA_W-1:0] sd,
                                  input bit in, input bit lv, input logic [1:0] lt, input bit ll);
        bit   nresp;
        bit   full;
        ent_t e;
        nresp = 1'b0;
        if (!rs || in) begin
            m_q.delete();
            m_buf.delete();
            m_state   = 0;
            m_wpos    = 0;
            m_pending = 1'b0;
            if (!rs) m_err = 1'b0;
        end else if (m_state != 2) begin
            if (s) m_err = 1'b1;
            if (lv) begin
                m_buf.push_back(lt);
                if (m_buf.size() == T_PER_WORD || ll) begin
                    m_q.push_back('{build_word(), m_wpos});
                    m_wpos = (m_wpos + 1) % m_wpp;
                    m_buf.delete();
                end
                m_state = ll ? 2 : 1;
                if (ll) m_wpos = 0;
            end
        end else begin
            full = (m_q.size() == m_wpp);
            if (m_pending || (r && !m_resp_now)) begin
                if (m_q.size() > 0) begin
                    e = m_q.pop_front();
                    exp_q.push_back('{{1'b1, hdr_cnt(e.pos), e.data}, cyc + 1});
                    m_pending = 1'b0;
                    nresp     = 1'b1;
                end else begin
                    m_pending = 1'b1;
                end
            end
            if (s) begin
                if (full) m_err = 1'b1;
                else begin
                    m_q.push_back('{sd, m_wpos});
                    m_wpos = (m_wpos + 1) % m_wpp;
                end
            end
        end
        m_resp_now = nresp;
        exp_err    = m_err;
        exp_ready  = (m_state != 2);
    endfunction

    // One clock of stimulus: check status from the previous edge, then drive and model.
    task automatic step(input bit rs, input bit r, input bit s, input logic [DATA_W-1:0] sd,
                        input bit in, input bit lv, input logic [1:0] lt, input bit ll);
        @(negedge clk);
        chk_int("o_error", int'(err), int'(exp_err));
        chk_int("o_load_ready", int'(load_ready), int'(exp_ready));
        rst_n      = rs;
        req        = r;
        send       = s;
        send_data  = {HEADER_BIT'($urandom), sd};
        init       = in;
        load_valid = lv;
        load_t     = lt;
        load_last  = ll;
        model(rs, r, s, sd, in, lv, lt, ll);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic do_req();
        step(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic do_send(input logic [DATA_W-1:0] d);
        step(1'b1, 1'b0, 1'b1, d, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic set_tsize(input int n);
        t_size = MAX_T_LOG'(n);
        m_wpp  = (n + T_PER_WORD - 1) / T_PER_WORD;
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 2'($urandom_range(0, 3)), i == n - 1);
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, ($urandom % 2) == 0, ($urandom % 3) == 0, {$urandom, $urandom}, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    // Monitor: every response on the bus must match the head of the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (req_data[HDR_VALID_BIT]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: got %h expected no response (cycle %0d)", req_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_word", req_data, mon_e.word);
                    chk_int("resp_cycle", cyc, mon_e.at);
                end
            end else begin
                chk("idle_bus_zero", req_data, '0);
                if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missed_response: got none expected %h at cycle %0d (cycle %0d)",
                             exp_q[0].word, exp_q[0].at, cyc);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int syms[10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
        rst_n      = 1'b0;
        req        = 1'b0;
        send       = 1'b0;
        send_data  = '0;
        init       = 1'b0;
        load_valid = 1'b0;
        load_t     = 2'd0;
        load_last  = 1'b0;
        set_tsize(10);
        m_state    = 0;
        m_wpos     = 0;
        m_pending  = 1'b0;
        m_resp_now = 1'b0;
        m_err      = 1'b0;

        // Reset state.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
        idle(2);

        // Load T_size=10 -> three words, last one {0,1,pad,pad}.
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 2'(syms[i]), i == 9);
        idle(1);

        // Three spaced requests: counts 0, 0, 2.
        for (int i = 0; i < 3; i++) begin
            do_req();
            idle(1);
        end
        idle(1);

        // Request on empty FIFO, send two cycles later.
        do_req();
        idle(1);
        do_send({$urandom, $urandom});
        idle(3);

        // Request held for three cycles: first and third are served.
        do_send({$urandom, $urandom});
        do_send({$urandom, $urandom});
        idle(1);
        do_req();
        do_req();
        do_req();
        idle(2);

        // Fill to wpp, overflow send, then concurrent read and write.
        do_send({$urandom, $urandom});
        do_send({$urandom, $urandom});
        do_send({$urandom, $urandom});
        do_send({$urandom, $urandom});
        idle(1);
        do_req();
        idle(1);
        step(1'b1, 1'b1, 1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 2'd0, 1'b0);
        idle(1);
        do_req();
        idle(1);
        do_req();
        idle(2);

        random_traffic(200);

        // Init together with a request: no response, back to IDLE.
        step(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0, 2'd0, 1'b0);
        idle(1);
`ifdef TSR_STALL_CNT_EN
        chk_int("stall_cnt_after_init", int'(stall_cnt), 0);
`endif
        idle(1);

        // Second pass with T_size a multiple of T_PER_WORD, then reset mid-pass.
        set_tsize(20);
        load_random(20);
        random_traffic(150);
        idle(2);
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
        idle(2);

        // Third pass with random T_size.
        set_tsize($urandom_range(5, 60));
        load_random(int'(t_size));
        random_traffic(250);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, 2'd0, 1'b0);
        idle(4);

        chk_int("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
